serial_paralelo_rx: RTL and testbench



---
 rtl/phy_pkg.sv | 14 +
 rtl/serial_paralelo_rx_if.sv | 21 ++
 rtl/serial_paralelo_rx_sipo.sv | 23 ++
 rtl/serial_paralelo_rx.sv | 116 +++++++++++
 tb/tb_serial_paralelo_rx.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/phy_pkg.sv
// Constants and state encodings shared by the PHY TX and RX stages.
package phy_pkg;

  localparam logic [7:0] BC_SYM       = 8'hBC;
  localparam logic [7:0] IDLE_SYM     = 8'h7C;
  localparam int         BC_COUNT_DEF = 4;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ALIGNED = 2'd1,
    ACTIVE  = 2'd2
  } rxState_t;

endpackage

// File: rtl/serial_paralelo_rx_if.sv
// Serial input and parallel byte outputs of the PHY receive stage.
interface serial_paralelo_rx_if;

  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       IDLE_OUT;
  logic       active;
  logic       byte_strobe;

  modport master (
    output data_in,
    input  data_out, valid_out, IDLE_OUT, active, byte_strobe
  );

  modport slave (
    input  data_in,
    output data_out, valid_out, IDLE_OUT, active, byte_strobe
  );

endinterface

// File: rtl/serial_paralelo_rx_sipo.sv
// 8-bit serial-in shift register, MSB first; nxt is the byte as it will be
// after the current edge, so decisions can be made on the LSB's own edge.
module sipo_shift8 (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_din,
  output logic [7:0] o_sr,
  output logic [7:0] o_nxt
);

  logic [7:0] r_sr;
  logic [7:0] w_nxt;

  assign w_nxt = {r_sr[6:0], i_din};
  assign o_sr  = r_sr;
  assign o_nxt = w_nxt;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_sr <= 8'h00;
    else         r_sr <= w_nxt;
  end

endmodule

// File: rtl/serial_paralelo_rx.sv
// PHY receive front end: comma-based byte alignment, link activation and
// delivery of parallel data/idle bytes to the lane demux.
module serial_paralelo_rx #(
  parameter logic [7:0] BC_SYM   = phy_pkg::BC_SYM,
  parameter logic [7:0] IDLE_SYM = phy_pkg::IDLE_SYM,
  parameter int         BC_COUNT = phy_pkg::BC_COUNT_DEF
) (
  input  logic                 clk_32f,
  input  logic                 reset,
  serial_paralelo_rx_if.slave  rx
);

  import phy_pkg::*;

  localparam logic [3:0] BC_TARGET = 4'(BC_COUNT);

  logic [7:0] w_sr;
  logic [7:0] w_nxt;
  logic       w_unusedSr;
  logic       w_boundary;
  logic       w_isComma;
  logic       w_isIdle;

  rxState_t   r_state;
  logic [2:0] r_bitCnt;
  logic [3:0] r_bcCnt;
  logic [7:0] r_dataOut;
  logic       r_validOut;
  logic       r_idleOut;
  logic       r_active;
  logic       r_byteStrobe;

  sipo_shift8 u_shift (
    .i_clk   (clk_32f),
    .i_reset (reset),
    .i_din   (rx.data_in),
    .o_sr    (w_sr),
    .o_nxt   (w_nxt)
  );

  // The registered byte is only useful for debug probing; decisions use nxt.
  assign w_unusedSr = ^w_sr;

  assign w_boundary = (r_bitCnt == 3'd7);
  assign w_isComma  = (w_nxt == BC_SYM);
  assign w_isIdle   = (w_nxt == IDLE_SYM);

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_state      <= SEARCH;
      r_bitCnt     <= 3'd0;
      r_bcCnt      <= 4'd0;
      r_dataOut    <= 8'h00;
      r_validOut   <= 1'b0;
      r_idleOut    <= 1'b0;
      r_active     <= 1'b0;
      r_byteStrobe <= 1'b0;
    end else begin
      r_validOut   <= 1'b0;
      r_idleOut    <= 1'b0;
      r_byteStrobe <= 1'b0;
      case (r_state)
        SEARCH: begin
          // Sliding match at any bit offset; the matching edge is bit 7 of a byte.
          if (w_isComma) begin
            r_bcCnt  <= 4'd1;
            r_bitCnt <= 3'd0;
            if (BC_TARGET == 4'd1) begin
              r_state  <= ACTIVE;
              r_active <= 1'b1;
            end else begin
              r_state <= ALIGNED;
            end
          end
        end
        ALIGNED: begin
          r_bitCnt <= r_bitCnt + 3'd1;
          if (w_boundary) begin
            r_byteStrobe <= 1'b1;
            if (w_isComma) begin
              r_bcCnt <= r_bcCnt + 4'd1;
              if (r_bcCnt + 4'd1 == BC_TARGET) begin
                r_state  <= ACTIVE;
                r_active <= 1'b1;
              end
            end else begin
              r_state <= SEARCH;
              r_bcCnt <= 4'd0;
            end
          end
        end
        ACTIVE: begin
          // Locked for good: commas are fillers, never a realignment trigger.
          r_bitCnt <= r_bitCnt + 3'd1;
          if (w_boundary) begin
            r_byteStrobe <= 1'b1;
            if (w_isIdle) begin
              r_idleOut <= 1'b1;
            end else if (!w_isComma) begin
              r_dataOut  <= w_nxt;
              r_validOut <= 1'b1;
            end
          end
        end
        default: r_state <= SEARCH;
      endcase
    end
  end

  assign rx.data_out    = r_dataOut;
  assign rx.valid_out   = r_validOut;
  assign rx.IDLE_OUT    = r_idleOut;
  assign rx.active      = r_active;
  assign rx.byte_strobe = r_byteStrobe;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Scoreboard bench for serial_paralelo_rx: the driver queues expected
// data/idle events, a negedge monitor pops and checks them.
module tb_serial_paralelo_rx;

  logic clk_32f = 1'b0;
  logic reset   = 1'b1;

  serial_paralelo_rx_if rxIf ();

  serial_paralelo_rx dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .rx      (rxIf)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    logic       isIdle;
    logic [7:0] data;
    int         cyc;
  } expEvt_t;

  expEvt_t    expQ[$];
  int         total    = 0;
  int         bad      = 0;
  int         cyc      = 0;
  logic [7:0] lastData = 8'h00;

  always @(posedge clk_32f) cyc <= cyc + 1;

  // Every data/idle pulse must match the head of the queue in kind, value and edge.
  always @(negedge clk_32f) begin
    expEvt_t e;
    if (rxIf.valid_out === 1'b1 || rxIf.IDLE_OUT === 1'b1) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_event: got valid=%b idle=%b data=%h at cyc %0d, required no event",
                 rxIf.valid_out, rxIf.IDLE_OUT, rxIf.data_out, cyc);
      end else begin
        e = expQ.pop_front();
        if (rxIf.IDLE_OUT !== e.isIdle || rxIf.valid_out !== !e.isIdle ||
            rxIf.data_out !== e.data || cyc != e.cyc) begin
          bad++;
          $display("[TB] FAIL scoreboard: got idle=%b valid=%b data=%h cyc=%0d, required idle=%b data=%h cyc=%0d",
                   rxIf.IDLE_OUT, rxIf.valid_out, rxIf.data_out, cyc, e.isIdle, e.data, e.cyc);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic sendBit(input logic b);
    rxIf.data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  // kind: 0 = no output expected, 1 = data byte, 2 = idle byte
  task automatic applyStimulus(input logic [7:0] b, input int kind);
    for (int i = 7; i >= 0; i--) sendBit(b[i]);
    if (kind == 1) begin
      expQ.push_back('{1'b0, b, cyc});
      lastData = b;
    end else if (kind == 2) begin
      expQ.push_back('{1'b1, lastData, cyc});
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    rxIf.data_in = 1'b0;
    repeat (2) @(posedge clk_32f);
    #1;
    reset = 1'b0;
    lastData = 8'h00;
    checkOutput("reset_data", rxIf.data_out, 8'h00);
    checkOutput("reset_flags", {4'b0, rxIf.valid_out, rxIf.IDLE_OUT, rxIf.active, rxIf.byte_strobe}, 8'h00);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] partial;
    rxIf.data_in = 1'b0;

    $display("[TB] test 1: offset alignment");
    doReset();
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
    applyStimulus(8'hBC, 0);
    checkOutput("t1_match_nostrobe", {6'b0, rxIf.byte_strobe, rxIf.active}, 8'h00);
    applyStimulus(8'hBC, 0);
    checkOutput("t1_bc2", {6'b0, rxIf.byte_strobe, rxIf.active}, 8'h02);
    sendBit(1'b1);
    checkOutput("t1_midbyte_strobe", {7'b0, rxIf.byte_strobe}, 8'h00);
    for (int i = 6; i >= 0; i--) sendBit(b8BC(i));
    checkOutput("t1_bc3", {6'b0, rxIf.byte_strobe, rxIf.active}, 8'h02);
    applyStimulus(8'hBC, 0);
    checkOutput("t1_bc4_active", {6'b0, rxIf.byte_strobe, rxIf.active}, 8'h03);

    $display("[TB] test 2: broken comma run");
    doReset();
    applyStimulus(8'hBC, 0);
    applyStimulus(8'hBC, 0);
    applyStimulus(8'h55, 0);
    checkOutput("t2_after55", {6'b0, rxIf.byte_strobe, rxIf.active}, 8'h02);
    for (int k = 0; k < 3; k++) applyStimulus(8'hBC, 0);
    checkOutput("t2_three_bc", {7'b0, rxIf.active}, 8'h00);
    applyStimulus(8'hBC, 0);
    checkOutput("t2_four_bc", {7'b0, rxIf.active}, 8'h01);

    $display("[TB] test 3: data then comma");
    applyStimulus(8'hA5, 1);
    checkOutput("t3_data", rxIf.data_out, 8'hA5);
    checkOutput("t3_valid", {7'b0, rxIf.valid_out}, 8'h01);
    applyStimulus(8'hBC, 0);
    checkOutput("t3_hold", rxIf.data_out, 8'hA5);
    checkOutput("t3_novalid", {6'b0, rxIf.valid_out, rxIf.IDLE_OUT}, 8'h00);

    $display("[TB] test 4: idle then data");
    applyStimulus(8'h7C, 2);
    checkOutput("t4_idle", {6'b0, rxIf.valid_out, rxIf.IDLE_OUT}, 8'h01);
    checkOutput("t4_idle_hold", rxIf.data_out, 8'hA5);
    applyStimulus(8'h3C, 1);
    checkOutput("t4_data", rxIf.data_out, 8'h3C);
    checkOutput("t4_flags", {6'b0, rxIf.valid_out, rxIf.IDLE_OUT}, 8'h02);

    $display("[TB] test 5: reset mid-byte");
    partial = 8'hE7;
    for (int i = 7; i >= 5; i--) sendBit(partial[i]);
    reset = 1'b1;
    sendBit(partial[4]);
    reset = 1'b0;
    lastData = 8'h00;
    checkOutput("t5_data", rxIf.data_out, 8'h00);
    checkOutput("t5_flags", {4'b0, rxIf.valid_out, rxIf.IDLE_OUT, rxIf.active, rxIf.byte_strobe}, 8'h00);
    for (int i = 3; i >= 0; i--) sendBit(partial[i]);
    applyStimulus(8'h12, 0);
    applyStimulus(8'h34, 0);
    for (int k = 0; k < 3; k++) applyStimulus(8'hBC, 0);
    checkOutput("t5_three_bc", {7'b0, rxIf.active}, 8'h00);
    applyStimulus(8'hBC, 0);
    checkOutput("t5_relock", {7'b0, rxIf.active}, 8'h01);
    applyStimulus(8'h99, 1);

    $display("[TB] test 6: random data stream");
    for (int k = 0; k < 100; k++) begin
      do b = 8'($urandom_range(0, 255)); while (b == 8'hBC || b == 8'h7C);
      applyStimulus(b, 1);
    end
    applyStimulus(8'hBC, 0);
    repeat (3) @(posedge clk_32f);
    #1;
    checkOutput("drain_queue", 8'(expQ.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic b8BC(input int i);
    logic [7:0] v;
    v = 8'hBC;
    return v[i];
  endfunction

endmodule
